// File: rtl/cdc_hs_tx.sv
// Source side of a 2-phase request/acknowledge handshake for sending a data
// word into another clock domain. The word is held on xfer_data while the
// request toggle is outstanding. The remote acknowledge toggle is
// resynchronised locally before anything uses it.
module cdc_hs_tx #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [DATA_W-1:0] src_data,
  output logic              xfer_req,
  output logic [DATA_W-1:0] xfer_data,
  input  logic              xfer_ack,
  output logic              done,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
);

  // A timeout of 0 disables the counter; it is kept 1 bit wide so the
  // declarations stay legal.
  localparam int unsigned    CNT_W  = (ACK_TIMEOUT == 0) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(ACK_TIMEOUT);
  localparam bit             TO_EN  = (ACK_TIMEOUT != 0);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_ACK = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   req_q, req_d;
  logic [DATA_W-1:0]      data_q, data_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic ack_sync;
  logic accept;

  assign ack_sync = sync_q[SYNC_STAGES-1];

  // The peer is in step with us when its acknowledge toggle matches our request toggle.
  assign src_ready = (state_q == IDLE) && (ack_sync == req_q);
  assign accept    = src_valid && src_ready;

  assign xfer_req    = req_q;
  assign xfer_data   = data_q;
  assign done        = done_q;
  assign busy        = (state_q == WAIT_ACK);
  assign timeout_err = err_q;

  // Shift chain on xfer_ack; only the last stage is used.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], xfer_ack};
  end

  // Next-state: accept a word, wait for the acknowledge, and track the timeout.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    err_d   = err_q && !err_clr;

    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d  = src_data;
          req_d   = !req_q;
          cnt_d   = '0;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (cnt_q != TO_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // The flag is raised only on the edge where the counter first saturates,
        // so a clear issued later while still waiting takes effect.
        if (TO_EN && (cnt_q != TO_MAX) && (cnt_d == TO_MAX)) begin
          err_d = 1'b1;
        end
        if (ack_sync == req_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync_q  <= '0;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_cdc_hs_tx.sv
// Directed bench for cdc_hs_tx with SYNC_STAGES=2 and ACK_TIMEOUT=8.
module tb_cdc_hs_tx;

  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              src_valid;
  logic              src_ready;
  logic [DATA_W-1:0] src_data;
  logic              xfer_req;
  logic [DATA_W-1:0] xfer_data;
  logic              xfer_ack;
  logic              done;
  logic              busy;
  logic              timeout_err;
  logic              err_clr;

  int n_tests = 0;
  int n_fail  = 0;

  cdc_hs_tx #(
    .DATA_W     (DATA_W),
    .SYNC_STAGES(2),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .xfer_req   (xfer_req),
    .xfer_data  (xfer_data),
    .xfer_ack   (xfer_ack),
    .done       (done),
    .busy       (busy),
    .timeout_err(timeout_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; src_valid = 1'b0; src_data = '0; xfer_ack = 1'b0; err_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    n_tests++; if (xfer_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", xfer_req); end
    n_tests++; if (xfer_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", xfer_data); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", timeout_err); end
    n_tests++; if (src_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", src_ready); end
  endtask

  task automatic test_single();
    src_valid = 1'b1; src_data = 32'hDEADBEEF;
    n_tests++; if (src_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_pre: got %0b want 1", src_ready); end
    tick();
    src_valid = 1'b0; src_data = 32'h0;
    n_tests++; if (xfer_req !== 1'b1) begin n_fail++; $display("FAIL single_req: got %0b want 1", xfer_req); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy: got %0b want 1", busy); end
    n_tests++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL single_ready_wait: got %0b want 0", src_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++; if (xfer_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_hold%0d: got %h want deadbeef", i, xfer_data); end
    end
    xfer_ack = 1'b1;
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_e0: got %0b want 0", done); end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_e1: got %0b want 0", done); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_e1: got %0b want 1", busy); end
    tick();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL single_done_e2: got %0b want 1", done); end
    n_tests++; if (src_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_done: got %0b want 1", src_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_done: got %0b want 0", busy); end
    n_tests++; if (xfer_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_hold_done: got %h want deadbeef", xfer_data); end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %0b want 0", done); end
  endtask

  task automatic test_stall();
    src_valid = 1'b1; src_data = 32'h12345678;
    tick();
    src_data = 32'hAAAA5555;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_tests++; if (xfer_data !== 32'h12345678) begin n_fail++; $display("FAIL stall_data%0d: got %h want 12345678", i, xfer_data); end
      n_tests++; if (xfer_req !== 1'b0) begin n_fail++; $display("FAIL stall_req%0d: got %0b want 0", i, xfer_req); end
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL stall_busy%0d: got %0b want 1", i, busy); end
    end
    src_valid = 1'b0;
    xfer_ack = 1'b0;
    tick(); tick(); tick();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %0b want 1", done); end
    n_tests++; if (xfer_data !== 32'h12345678) begin n_fail++; $display("FAIL stall_data_end: got %h want 12345678", xfer_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [4];
    logic [31:0] captured [4];
    int          acc_cyc [4];
    int          n_acc, done_cnt, echo_cnt;
    logic        prev_req;
    words[0] = 32'h11111111; words[1] = 32'h22222222;
    words[2] = 32'h33333333; words[3] = 32'h44444444;
    for (int i = 0; i < 4; i++) begin captured[i] = '0; acc_cyc[i] = 0; end
    n_acc = 0; done_cnt = 0; echo_cnt = 0;
    prev_req = xfer_req;
    for (int cyc = 0; cyc < 200 && done_cnt < 4; cyc++) begin
      src_valid = (n_acc < 4);
      src_data  = (n_acc < 4) ? words[n_acc] : 32'h0;
      tick();
      if (xfer_req !== prev_req && n_acc < 4) begin
        captured[n_acc] = xfer_data;
        acc_cyc[n_acc]  = cyc;
        n_acc++;
        prev_req = xfer_req;
      end
      if (done === 1'b1) done_cnt++;
      // Receiver: echo the request toggle two cycles after seeing it change.
      if (xfer_req !== xfer_ack) begin
        echo_cnt++;
        if (echo_cnt == 2) begin
          xfer_ack = xfer_req;
          echo_cnt = 0;
        end
      end else begin
        echo_cnt = 0;
      end
    end
    src_valid = 1'b0;
    n_tests++; if (n_acc != 4) begin n_fail++; $display("FAIL b2b_accepts: got %0d want 4", n_acc); end
    n_tests++; if (done_cnt != 4) begin n_fail++; $display("FAIL b2b_done: got %0d want 4", done_cnt); end
    n_tests++; if (xfer_req !== 1'b0) begin n_fail++; $display("FAIL b2b_req_end: got %0b want 0", xfer_req); end
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (captured[i] !== words[i]) begin n_fail++; $display("FAIL b2b_word%0d: got %h want %h", i, captured[i], words[i]); end
    end
    for (int i = 1; i < 4; i++) begin
      n_tests++; if (acc_cyc[i] - acc_cyc[i-1] != 5) begin n_fail++; $display("FAIL b2b_gap%0d: got %0d want 5", i, acc_cyc[i] - acc_cyc[i-1]); end
    end
    tick();
  endtask

  task automatic test_timeout();
    src_valid = 1'b1; src_data = 32'hCAFEF00D;
    tick();
    src_valid = 1'b0;
    repeat (7) tick();
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_early: got %0b want 0", timeout_err); end
    tick();
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_set: got %0b want 1", timeout_err); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_busy: got %0b want 1", busy); end
    n_tests++; if (xfer_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL to_data: got %h want cafef00d", xfer_data); end
    n_tests++; if (xfer_req !== 1'b1) begin n_fail++; $display("FAIL to_req: got %0b want 1", xfer_req); end
    repeat (3) tick();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL to_still_busy: got %0b want 1", busy); end
    xfer_ack = 1'b1;
    tick(); tick(); tick();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL to_late_done: got %0b want 1", done); end
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %0b want 1", timeout_err); end
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clear: got %0b want 0", timeout_err); end
    // Second transfer: clear lands on the same edge as the new timeout.
    src_valid = 1'b1; src_data = 32'h0BADF00D;
    tick();
    src_valid = 1'b0;
    repeat (7) tick();
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to2_early: got %0b want 0", timeout_err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_set_wins: got %0b want 1", timeout_err); end
    xfer_ack = 1'b0;
    tick(); tick(); tick();
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL to2_done: got %0b want 1", done); end
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to2_clear: got %0b want 0", timeout_err); end
  endtask

  task automatic test_reset_mid();
    logic done_seen;
    src_valid = 1'b1; src_data = 32'h55AA55AA;
    tick();
    src_valid = 1'b0;
    n_tests++; if (xfer_req !== 1'b1) begin n_fail++; $display("FAIL rm_req_pre: got %0b want 1", xfer_req); end
    xfer_ack = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++; if (xfer_req !== 1'b0) begin n_fail++; $display("FAIL rm_req: got %0b want 0", xfer_req); end
    n_tests++; if (xfer_data !== 32'h0) begin n_fail++; $display("FAIL rm_data: got %h want 0", xfer_data); end
    done_seen = done;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1) done_seen = 1'b1;
    end
    n_tests++; if (done_seen !== 1'b0) begin n_fail++; $display("FAIL rm_no_done: got %0b want 0", done_seen); end
    n_tests++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready_low: got %0b want 0", src_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %0b want 0", busy); end
    xfer_ack = 1'b0;
    tick();
    n_tests++; if (src_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready_e0: got %0b want 0", src_ready); end
    tick();
    n_tests++; if (src_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_e1: got %0b want 1", src_ready); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rm_done_end: got %0b want 0", done); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_hs_tx.md
CDC_HS_TX -- requirements
Module: cdc_hs_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of the transferred data word.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, minimum 2, meaning the number of synchronizer flops on xfer_ack.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 1024, meaning WAIT_ACK cycles before timeout_err sets; 0 disables the timeout.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port src_valid, input, 1 bit: source offers src_data.
REQ-007 SHALL have port src_ready, output, 1 bit: block can accept a word this cycle.
REQ-008 SHALL have port src_data, input, DATA_W bits: word to transfer.
REQ-009 SHALL have port xfer_req, output, 1 bit: 2-phase request toggle to the remote domain, driven directly from a flop.
REQ-010 SHALL have port xfer_data, output, DATA_W bits: held data bus to the remote domain, driven directly from flops.
REQ-011 SHALL have port xfer_ack, input, 1 bit: asynchronous 2-phase acknowledge toggle from the remote receiver.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a transfer is acknowledged.
REQ-013 SHALL have port busy, output, 1 bit: high while in WAIT_ACK.
REQ-014 SHALL have port timeout_err, output, 1 bit: sticky timeout flag.
REQ-015 SHALL have port err_clr, input, 1 bit: clears timeout_err.

Function
REQ-016 SHALL pass xfer_ack through a chain of SYNC_STAGES flops to form ack_sync; no other logic SHALL use xfer_ack.
REQ-017 SHALL implement two states: IDLE and WAIT_ACK.
REQ-018 src_ready SHALL equal (state==IDLE) && (ack_sync==xfer_req), combinationally.
REQ-019 On a clock edge with src_valid && src_ready, the block SHALL load xfer_data <= src_data, toggle xfer_req, clear the timeout counter, and enter WAIT_ACK.
REQ-020 xfer_data SHALL change only on an accept edge, so it is stable whenever xfer_req differs from ack_sync.
REQ-021 In WAIT_ACK, on an edge where ack_sync==xfer_req, the block SHALL return to IDLE and set done high for exactly the following cycle.
REQ-022 Acknowledge latency: done SHALL be high in the cycle beginning SYNC_STAGES+1 rising edges after the first edge that samples the toggled xfer_ack.
REQ-023 The earliest next accept SHALL occur in the same cycle that done is high. This gives back-to-back throughput of one word per (round-trip + SYNC_STAGES + 1) cycles.
REQ-024 busy SHALL be high exactly when state==WAIT_ACK.
REQ-025 The timeout counter SHALL be ceil(log2(ACK_TIMEOUT+1)) bits wide, count WAIT_ACK cycles only, and saturate at ACK_TIMEOUT.
REQ-026 When the counter reaches ACK_TIMEOUT (and ACK_TIMEOUT!=0), timeout_err SHALL set on that edge.
REQ-027 A timeout SHALL NOT abort the transfer; the block SHALL stay in WAIT_ACK with xfer_data and xfer_req held.
REQ-028 err_clr SHALL clear timeout_err on the next edge; if set and clear coincide, set SHALL win.
REQ-029 src_valid while src_ready is low SHALL be ignored, with no state change.
REQ-030 If ack_sync!=xfer_req in IDLE (peer out of step, e.g. after a local-only reset), src_ready SHALL stay low until they match, with no done pulse and no counting.

Reset
REQ-031 While rst is high at an edge, all of the following SHALL clear: state to IDLE, xfer_req=0, xfer_data=0, all sync flops=0, done=0, timeout_err=0, counter=0.
REQ-032 Reset mid-transfer SHALL abandon the transfer silently: no done pulse, and src_ready is governed by REQ-030 after reset.
REQ-033 Outputs SHALL be valid starting the first cycle after rst deasserts; rst SHALL take priority over all other inputs.

Verification
REQ-034 Single transfer (SYNC_STAGES=2): accept 0xDEADBEEF, toggle xfer_ack 3 cycles after xfer_req toggles -> xfer_req=1, xfer_data=0xDEADBEEF held throughout, done one cycle 3 edges after ack is sampled, src_ready high with done.
REQ-035 Back-to-back: src_valid held high with 4 words, receiver echoing ack after 2 cycles -> 4 done pulses, xfer_req toggles 4 times ending at 0, no word lost or duplicated.
REQ-036 Timeout: ACK_TIMEOUT=8, ack never returned -> timeout_err rises after 8 WAIT_ACK cycles with busy still high; late ack then gives done; err_clr with no new timeout clears the flag; set and clear in the same cycle leaves it set.
REQ-037 Stall: src_valid pulsed during WAIT_ACK -> ignored, xfer_data unchanged.
REQ-038 Reset mid-transfer with xfer_ack left at 1 -> after reset xfer_req=0, no done, src_ready=0; driving xfer_ack to 0 -> src_ready rises 2 edges later.
